// File: rtl/proc_sequencer_if.sv
// Handshake and control bundle between the sequencer and its datapath.
// Signal names follow the processor's established control-line names.
interface proc_sequencer_if #(
  parameter int unsigned DIN_W = 9
) ();

  logic             Run;
  logic [DIN_W-1:0] DIN;
  logic             IRin;
  logic [0:7]       Rin;
  logic [0:7]       Rout;
  logic             Ain;
  logic             Gin;
  logic             Gout;
  logic             DINout;
  logic             AddSub;
  logic             Done;
  logic [1:0]       Tstep;

  modport master (
    output Run, DIN,
    input  IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done, Tstep
  );

  modport slave (
    input  Run, DIN,
    output IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done, Tstep
  );

endinterface

// File: rtl/proc_sequencer.sv
// Control unit for the memoryless processor: fetches a 9-bit instruction in T0
// and sequences register/ALU enables through T1..T3.
module proc_sequencer #(
  parameter int unsigned DIN_W = 9
) (
  input  logic            Clock,
  input  logic            Reset,
  proc_sequencer_if.slave bus
);

  localparam int unsigned IR_W   = 9;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned NREG   = 8;

  localparam logic [OP_W-1:0] OP_MV  = 3'b000;
  localparam logic [OP_W-1:0] OP_MVI = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_e;

  step_e             step_q, step_d;
  logic [IR_W-1:0]   ir_q, ir_d;

  logic [OP_W-1:0]   op;
  logic [0:NREG-1]   x_oh;
  logic [0:NREG-1]   y_oh;

  logic              irin;
  logic [0:NREG-1]   rin;
  logic [0:NREG-1]   rout;
  logic              ain;
  logic              gin;
  logic              gout;
  logic              dinout;
  logic              addsub;
  logic              done;

  // Register index 0 maps to the leftmost enable bit.
  function automatic logic [0:NREG-1] dec_onehot(input logic [OP_W-1:0] idx);
    logic [0:NREG-1] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign op   = ir_q[8:6];
  assign x_oh = dec_onehot(ir_q[5:3]);
  assign y_oh = dec_onehot(ir_q[2:0]);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      step_q <= T0;
      ir_q   <= '0;
    end else begin
      step_q <= step_d;
      ir_q   <= ir_d;
    end
  end

  // Next-step and control decode from (step, IR), with Run consulted only in T0.
  always_comb begin
    step_d = step_q;
    ir_d   = ir_q;
    irin   = 1'b0;
    rin    = '0;
    rout   = '0;
    ain    = 1'b0;
    gin    = 1'b0;
    gout   = 1'b0;
    dinout = 1'b0;
    addsub = 1'b0;
    done   = 1'b0;

    case (step_q)
      T0: begin
        if (bus.Run) begin
          irin   = 1'b1;
          ir_d   = bus.DIN[DIN_W-1 -: IR_W];
          step_d = T1;
        end
      end

      T1: begin
        case (op)
          OP_MV: begin
            rout   = y_oh;
            rin    = x_oh;
            done   = 1'b1;
            step_d = T0;
          end
          OP_MVI: begin
            dinout = 1'b1;
            rin    = x_oh;
            done   = 1'b1;
            step_d = T0;
          end
          OP_ADD, OP_SUB: begin
            rout   = x_oh;
            ain    = 1'b1;
            step_d = T2;
          end
          default: begin
            done   = 1'b1;
            step_d = T0;
          end
        endcase
      end

      T2: begin
        rout   = y_oh;
        gin    = 1'b1;
        addsub = (op == OP_SUB);
        step_d = T3;
      end

      T3: begin
        gout   = 1'b1;
        rin    = x_oh;
        done   = 1'b1;
        step_d = T0;
      end

      default: step_d = T0;
    endcase
  end

  // Reset silences every control line for as long as it is held.
  assign bus.IRin   = Reset ? 1'b0 : irin;
  assign bus.Rin    = Reset ? '0   : rin;
  assign bus.Rout   = Reset ? '0   : rout;
  assign bus.Ain    = Reset ? 1'b0 : ain;
  assign bus.Gin    = Reset ? 1'b0 : gin;
  assign bus.Gout   = Reset ? 1'b0 : gout;
  assign bus.DINout = Reset ? 1'b0 : dinout;
  assign bus.AddSub = Reset ? 1'b0 : addsub;
  assign bus.Done   = Reset ? 1'b0 : done;
  assign bus.Tstep  = step_q;

endmodule

// File: doc/proc_sequencer.md
# proc_sequencer

Control unit for the simple processor without memory. It latches each 9-bit instruction from `DIN`, steps through time slots T0–T3, and drives the register-file enables as one-hot vectors, plus the A/G/IR load enables, the bus-source selects and the adder/subtractor mode. It sits between the external `Run`/`DIN` inputs and the register-file/ALU datapath, and asserts `Done` when each instruction retires.

## Interface

Parameters:
- `DIN_W`, default 9: width of `DIN`. The instruction occupies `DIN[DIN_W-1 -: 9]` as {III, XXX, YYY}.

Ports:
- `Clock`  in  1: single clock; all state updates on the rising edge.
- `Reset`  in  1: synchronous, active-high.
- `Run`  in  1: start request; sampled only in T0.
- `DIN`  in  DIN_W: instruction word in T0; immediate operand (routed by the datapath) in T1 of `mvi`.
- `IRin`  out  1: instruction-register load strobe, mirrored for the datapath.
- `Rin`  out  [0:7]: one-hot register load enables; bit i loads Ri, so bit 0 is the leftmost.
- `Rout`  out  [0:7]: one-hot register bus drive; same bit ordering as `Rin`.
- `Ain`, `Gin`, `Gout`, `DINout`  out  1 each: A load, G load, G bus drive, DIN bus drive.
- `AddSub`  out  1: 0 = add, 1 = subtract.
- `Done`  out  1: high in the final step of an instruction.
- `Tstep`  out  2: current step (0–3), for debug and verification.

## Operation

- Internal state:
  - 2-bit step counter `Tstep`.
  - 9-bit `IR`, which is {III = IR[8:6], XXX = IR[5:3], YYY = IR[2:0]}.
- X one-hot is derived from XXX and Y one-hot from YYY. The encoding is 000 → 8'b1000_0000 and 111 → 8'b0000_0001.
- Opcodes:
  - 000 `mv Rx,Ry`: T1 = Rout=Y, Rin=X, Done.
  - 001 `mvi Rx,#D`: T1 = DINout, Rin=X, Done.
  - 010 `add Rx,Ry`: T1 = Rout=X, Ain. T2 = Rout=Y, Gin, AddSub=0. T3 = Gout, Rin=X, Done.
  - 011 `sub Rx,Ry`: same as `add` except AddSub=1 in T2.
  - 100–111: NOP. T1 asserts Done only; all enables stay 0.
- T0 (idle/fetch):
  - IRin = Run. When Run=1, IR <= DIN[DIN_W-1 -: 9] at the edge and Tstep -> 1.
  - When Run=0, stay in T0 and hold IR.
- Step counter:
  - Tstep increments each cycle while not in T0.
  - The edge following a Done cycle returns Tstep to 0.
- Outputs are combinational from (Tstep, IR), plus Run in T0 only. All enables are 0 in any step not listed above.
- Bus rule: at most one of {any Rout bit, Gout, DINout} is 1 in any cycle. Rin, when active, has exactly one bit set.
- Run is ignored outside T0. Back-to-back instructions need Run high again in the T0 that follows Done.

## Timing

- Latency from the Run=1 cycle in T0 to the Done cycle:
  - `mv`, `mvi`, NOP: 1 cycle (Done in the next cycle).
  - `add`, `sub`: 3 cycles.
- Instruction throughput: 2 cycles for `mv`/`mvi`, 4 cycles for `add`/`sub`, T0 included.
- Reset (Reset=1 at an edge), in any step including mid-instruction:
  - Next state is Tstep=0, IR=9'b0.
  - While Reset=1, all outputs are forced to 0: `Rin`, `Rout`, `Ain`, `Gin`, `Gout`, `DINout`, `AddSub`, `IRin`, `Done`.
  - After release, outputs are 0 with Run low.
- Reset and Run high in the same cycle: Reset wins, IR is not loaded, and `IRin` is 0.

## Test plan

- Reset, then Run with DIN=9'b001_000_000, then DIN=5:
  - T0: IRin=1.
  - Next cycle: DINout=1, Rin=8'b1000_0000, Done=1.
  - Following cycle: Tstep=0.
- `mv R3,R5` (9'b000_011_101): one cycle after T0, Rout=8'b0000_0100, Rin=8'b0001_0000, Done=1. No other enables.
- `sub R1,R2` (9'b011_001_010):
  - T1: Rout=0100_0000, Ain=1.
  - T2: Rout=0010_0000, Gin=1, AddSub=1.
  - T3: Gout=1, Rin=0100_0000, Done=1.
  - Then back to T0.
- Opcode 9'b110_111_111: T1 has Done=1 and all enables 0. Run toggled during T1 has no effect.
- Reset asserted in T2 of an `add`:
  - Outputs are 0 during Reset.
  - Next cycle: Tstep=0, IR=0.
  - A subsequent `mvi` executes normally.
- Every cycle of a random instruction stream: bus-drive one-hot rule holds, and Run is ignored outside T0.
